// File: rtl/hmac512_pkg.sv
// Shared types for the SHA-512/HMAC-512 message path.
// Holds the FIFO entry layout, packer states and the message length width.
package hmac512_pkg;

  localparam int MsgLenW = 128;

  typedef logic [63:0] sha_word_t;

  typedef struct packed {
    sha_word_t  data;
    logic [7:0] mask;
  } sha_fifo_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFlush,
    StDone
  } pack_st_e;

endpackage

// File: rtl/sha512_byte_align.sv
// Appends beat bytes after the staged bytes; byte 0 sits in the low lane.
// Reports whether eight bytes are now available and the leftover count.
module sha512_byte_align
  import hmac512_pkg::*;
(
  input  logic [6:0][7:0]  stage_i,
  input  logic [2:0]       stage_cnt_i,
  input  logic [3:0][7:0]  beat_i,
  input  logic [2:0]       n_i,
  output logic [10:0][7:0] cat_o,
  output logic             word_full_o,
  output logic [2:0]       stage_cnt_o
);

  logic [3:0]  sum;
  logic [87:0] stg_x;
  logic [87:0] bt_x;

  always_comb begin
    sum = {1'b0, stage_cnt_i} + {1'b0, n_i};
    stg_x = {32'b0, stage_i} & ~({88{1'b1}} << {stage_cnt_i, 3'b000});
    bt_x = {56'b0, beat_i} & ~({88{1'b1}} << {n_i, 3'b000});
    cat_o = stg_x | (bt_x << {stage_cnt_i, 3'b000});
  end

  // Low three bits of the sum are the leftover count once a word is cut.
  assign word_full_o = sum[3];
  assign stage_cnt_o = sum[2:0];

endmodule

// File: rtl/sha512_msg_pack.sv
// Packs 32-bit strobed message beats into 64-bit big-endian FIFO entries.
// Define SHA512_MSG_BYTE_SWAP_EN to take msg_data_i[31:24] as the first byte.
module sha512_msg_pack
  import hmac512_pkg::*;
#(
  parameter int BufWords = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               sha_en_i,
  input  logic               hash_start_i,
  input  logic               hash_process_i,
  input  logic               msg_valid_i,
  input  logic [31:0]        msg_data_i,
  input  logic [3:0]         msg_strb_i,
  output logic               msg_ready_o,
  output logic               fifo_wvalid_o,
  output logic [63:0]        fifo_wdata_o,
  output logic [7:0]         fifo_wmask_o,
  input  logic               fifo_wready_i,
  output logic [MsgLenW-1:0] message_length_o,
  output logic               pack_done_o,
  output logic               err_o
);

  if (BufWords != 1) begin : g_bad_buf
    $error("sha512_msg_pack: only BufWords == 1 is supported");
  end

  pack_st_e           st_q, st_d;
  logic [6:0][7:0]    stage_q, stage_d;
  logic [2:0]         cnt_q, cnt_d;
  sha_fifo_t          out_q, out_d;
  logic               out_vld_q, out_vld_d;
  logic [MsgLenW-1:0] len_q, len_d;
  logic               err_q, err_d;

  logic [3:0][7:0]    beat;
  logic [3:0]         strb;
  logic [2:0]         n;
  logic               strb_ok;
  logic [10:0][7:0]   cat;
  logic               full;
  logic [2:0]         cnt_nxt;
  logic               slot_free;
  logic               ready;
  logic               acc;
  sha_word_t          flush_data;

`ifdef SHA512_MSG_BYTE_SWAP_EN
  assign beat = {msg_data_i[7:0], msg_data_i[15:8],
                 msg_data_i[23:16], msg_data_i[31:24]};
  assign strb = {msg_strb_i[0], msg_strb_i[1],
                 msg_strb_i[2], msg_strb_i[3]};
`else
  assign beat = msg_data_i;
  assign strb = msg_strb_i;
`endif

  always_comb begin
    n = 3'd0;
    strb_ok = 1'b1;
    unique case (1'b1)
      (strb == 4'b0001): n = 3'd1;
      (strb == 4'b0011): n = 3'd2;
      (strb == 4'b0111): n = 3'd3;
      (strb == 4'b1111): n = 3'd4;
      default:           strb_ok = 1'b0;
    endcase
  end

  sha512_byte_align u_align (
    .stage_i     (stage_q),
    .stage_cnt_i (cnt_q),
    .beat_i      (beat),
    .n_i         (n),
    .cat_o       (cat),
    .word_full_o (full),
    .stage_cnt_o (cnt_nxt)
  );

  always_comb begin
    flush_data = '0;
    for (int i = 0; i < 7; i++) begin
      flush_data[63-8*i -: 8] = stage_q[i];
    end
  end

  assign slot_free = !out_vld_q || fifo_wready_i;
  // Idle and Done swallow beats so a stray writer never stalls the bus.
  assign ready = (st_q == StAccum) ? slot_free : (st_q != StFlush);
  assign acc = msg_valid_i && ready;

  always_comb begin
    st_d = st_q;
    stage_d = stage_q;
    cnt_d = cnt_q;
    out_d = out_q;
    out_vld_d = out_vld_q;
    len_d = len_q;
    err_d = 1'b0;
    if (out_vld_q && fifo_wready_i) begin
      out_vld_d = 1'b0;
    end
    if (hash_start_i) begin
      stage_d = '0;
      cnt_d = '0;
      out_d = '0;
      out_vld_d = 1'b0;
      len_d = '0;
      st_d = sha_en_i ? StAccum : StIdle;
    end else begin
      unique case (st_q)
        StIdle, StDone: begin
          err_d = acc;
        end
        StAccum: begin
          if (acc) begin
            if (!sha_en_i || !strb_ok) begin
              err_d = 1'b1;
            end else begin
              len_d = len_q + MsgLenW'({n, 3'b000});
              cnt_d = cnt_nxt;
              if (full) begin
                for (int i = 0; i < 8; i++) begin
                  out_d.data[63-8*i -: 8] = cat[i];
                end
                out_d.mask = 8'hFF;
                out_vld_d = 1'b1;
                stage_d = {32'b0, cat[10:8]};
              end else begin
                stage_d = cat[6:0];
              end
            end
          end
          if (hash_process_i) begin
            st_d = StFlush;
          end
        end
        StFlush: begin
          if (cnt_q == 3'd0) begin
            st_d = StDone;
          end else if (slot_free) begin
            out_d.data = flush_data;
            out_d.mask = ~(8'hFF >> cnt_q);
            out_vld_d = 1'b1;
            stage_d = '0;
            cnt_d = '0;
            st_d = StDone;
          end
        end
        default: st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q <= StIdle;
      stage_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      out_vld_q <= 1'b0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      stage_q <= stage_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      out_vld_q <= out_vld_d;
      len_q <= len_d;
      err_q <= err_d;
    end
  end

  assign msg_ready_o = ready;
  assign fifo_wvalid_o = out_vld_q;
  assign fifo_wdata_o = out_q.data;
  assign fifo_wmask_o = out_q.mask;
  assign message_length_o = len_q;
  assign pack_done_o = (st_q == StDone) && !out_vld_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_sha512_msg_pack.sv
// Randomized bench for sha512_msg_pack against a byte-queue reference model.
// Honours SHA512_MSG_BYTE_SWAP_EN when building beats and strobes.
module tb_sha512_msg_pack;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         sha_en_i = 1'b1;
  logic         hash_start_i = 1'b0;
  logic         hash_process_i = 1'b0;
  logic         msg_valid_i = 1'b0;
  logic [31:0]  msg_data_i = '0;
  logic [3:0]   msg_strb_i = '0;
  logic         msg_ready_o;
  logic         fifo_wvalid_o;
  logic [63:0]  fifo_wdata_o;
  logic [7:0]   fifo_wmask_o;
  logic         fifo_wready_i = 1'b1;
  logic [127:0] message_length_o;
  logic         pack_done_o;
  logic         err_o;

  sha512_msg_pack dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .sha_en_i         (sha_en_i),
    .hash_start_i     (hash_start_i),
    .hash_process_i   (hash_process_i),
    .msg_valid_i      (msg_valid_i),
    .msg_data_i       (msg_data_i),
    .msg_strb_i       (msg_strb_i),
    .msg_ready_o      (msg_ready_o),
    .fifo_wvalid_o    (fifo_wvalid_o),
    .fifo_wdata_o     (fifo_wdata_o),
    .fifo_wmask_o     (fifo_wmask_o),
    .fifo_wready_i    (fifo_wready_i),
    .message_length_o (message_length_o),
    .pack_done_o      (pack_done_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef logic [71:0] ent_t;

  logic [7:0]   m_bytes[$];
  ent_t         m_exp[$];
  logic [127:0] m_len = '0;
  bit           m_active = 0;
  int           err_exp = 0;
  int           err_seen = 0;
  int           n_ent = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [63:0]  last_data = '0;
  logic [7:0]   last_mask = '0;
  bit           stall = 0;
  logic [71:0]  prev = '0;
  bit           bp_rand = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sb(input int n);
    logic [3:0] s;
    s = 4'((1 << n) - 1);
`ifdef SHA512_MSG_BYTE_SWAP_EN
    s = {s[0], s[1], s[2], s[3]};
`endif
    return s;
  endfunction

  function automatic int nbytes(input logic [3:0] s);
`ifdef SHA512_MSG_BYTE_SWAP_EN
    s = {s[0], s[1], s[2], s[3]};
`endif
    case (s)
      4'h1: return 1;
      4'h3: return 2;
      4'h7: return 3;
      4'hF: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] bbyte(input logic [31:0] d, input int k);
`ifdef SHA512_MSG_BYTE_SWAP_EN
    return d[31-8*k -: 8];
`else
    return d[8*k +: 8];
`endif
  endfunction

  function automatic logic [31:0] pk(input logic [7:0] b0, b1, b2, b3);
`ifdef SHA512_MSG_BYTE_SWAP_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  task automatic push_entry(input int cnt);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < cnt; i++) w[63-8*i -: 8] = m_bytes.pop_front();
    m_exp.push_back({w, 8'(8'hFF << (8 - cnt))});
  endtask

  task automatic model_beat(input logic [31:0] d, input logic [3:0] s);
    int n;
    n = nbytes(s);
    if (!m_active || !sha_en_i || n == 0) begin
      err_exp++;
    end else begin
      for (int k = 0; k < n; k++) m_bytes.push_back(bbyte(d, k));
      m_len += 128'(n * 8);
      while (m_bytes.size() >= 8) push_entry(8);
    end
  endtask

  task automatic model_flush();
    if (m_active) begin
      if (m_bytes.size() > 0) push_entry(m_bytes.size());
      m_active = 0;
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (stall)
        chk("hold_stable", {fifo_wvalid_o, fifo_wdata_o, fifo_wmask_o},
            {1'b1, prev});
      stall = fifo_wvalid_o && !fifo_wready_i && !hash_start_i;
      prev = {fifo_wdata_o, fifo_wmask_o};
      if (fifo_wvalid_o && fifo_wready_i) begin
        if (m_exp.size() == 0) begin
          chk("extra_entry", {fifo_wdata_o, fifo_wmask_o}, 0);
        end else begin
          ent_t e;
          e = m_exp.pop_front();
          chk("wdata", fifo_wdata_o, e[71:8]);
          chk("wmask", fifo_wmask_o, e[7:0]);
          n_ent++;
          last_data = fifo_wdata_o;
          last_mask = fifo_wmask_o;
        end
      end
      if (err_o) err_seen++;
    end
  end

  always begin
    @(posedge clk_i);
    #1;
    if (bp_rand) fifo_wready_i = ($urandom % 4) != 0;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start(input bit en);
    sha_en_i = en;
    hash_start_i = 1;
    tick();
    hash_start_i = 0;
    m_bytes.delete();
    m_exp.delete();
    m_len = '0;
    m_active = en;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] s,
                      input bit proc = 0);
    bit acc;
    acc = 0;
    msg_valid_i = 1;
    msg_data_i = d;
    msg_strb_i = s;
    hash_process_i = proc;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk_i);
      if (msg_ready_o) begin
        acc = 1;
        model_beat(d, s);
      end
      if (hash_process_i) model_flush();
      tick();
      hash_process_i = 0;
      if (acc) msg_valid_i = 0;
    end
    msg_valid_i = 0;
    if (!acc) chk("beat_accept", 0, 1);
    chk("msg_len", message_length_o, m_len);
  endtask

  task automatic wait_done(input int lat);
    int k;
    k = 1;
    while (k < 60) begin
      @(negedge clk_i);
      if (pack_done_o) break;
      k++;
    end
    if (lat > 0) chk("flush_lat", k, lat);
    else chk("pack_done", pack_done_o, 1);
    tick();
    chk("drained", m_exp.size(), 0);
  endtask

  task automatic flush(input int lat);
    hash_process_i = 1;
    model_flush();
    tick();
    hash_process_i = 0;
    wait_done(lat);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int e0;
    logic [3:0] bad[5];
    bad = '{4'h0, 4'h5, 4'hA, 4'h9, 4'h2};
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_wvalid", fifo_wvalid_o, 0);
    chk("rst_wdata", fifo_wdata_o, 0);
    chk("rst_wmask", fifo_wmask_o, 0);
    chk("rst_len", message_length_o, 0);
    chk("rst_done", pack_done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", msg_ready_o, 1);
    rst_ni = 1;
    tick();

    start(1);
    n0 = n_ent;
    send(pk(8'h00, 8'h01, 8'h02, 8'h03), sb(4));
    send(pk(8'h04, 8'h05, 8'h06, 8'h07), sb(4));
    repeat (2) tick();
    chk("full_count", n_ent - n0, 1);
    chk("full_data", last_data, 64'h0001020304050607);
    chk("full_mask", last_mask, 8'hFF);
    flush(2);

    start(1);
    n0 = n_ent;
    send(pk(8'hAA, 8'h00, 8'h00, 8'h00), sb(1));
    send(pk(8'h11, 8'h22, 8'h33, 8'h44), sb(4));
    send(pk(8'h55, 8'h66, 8'h00, 8'h00), sb(2));
    repeat (2) tick();
    chk("no_early_word", n_ent - n0, 0);
    flush(3);
    chk("part_data", last_data, 64'hAA11223344556600);
    chk("part_mask", last_mask, 8'hFE);
    chk("part_len", message_length_o, 56);
    repeat (3) tick();
    chk("done_held", pack_done_o, 1);

    start(1);
    n0 = n_ent;
    send(pk(8'h00, 8'h01, 8'h02, 8'h03), sb(4));
    send(pk(8'h04, 8'h05, 8'h06, 8'h07), sb(4));
    send(pk(8'h08, 8'h09, 8'h0A, 8'h0B), sb(4));
    flush(3);
    chk("carry_count", n_ent - n0, 2);
    chk("carry_data", last_data, 64'h08090A0B00000000);
    chk("carry_mask", last_mask, 8'hF0);
    chk("carry_len", message_length_o, 96);

    start(1);
    n0 = n_ent;
    fifo_wready_i = 0;
    send(32'h1111_1111, sb(4));
    send(32'h2222_2222, sb(4));
    @(negedge clk_i);
    chk("bp_ready_low", msg_ready_o, 0);
    tick();
    fork
      begin
        repeat (10) @(posedge clk_i);
        #1 fifo_wready_i = 1;
      end
    join_none
    send(32'h3333_3333, sb(4));
    send(32'h4444_4444, sb(4));
    flush(0);
    chk("bp_count", n_ent - n0, 2);

    start(1);
    send(32'hA1B2C3D4, sb(4));
    send(32'h0000E5F6, sb(2), 1);
    wait_done(0);
    chk("proc_beat_mask", last_mask, 8'hFC);
    chk("proc_beat_len", message_length_o, 48);

    start(1);
    e0 = err_seen;
    send(32'hDEADBEEF, 4'b0101);
    start(0);
    send(32'hCAFEF00D, sb(4));
    repeat (2) tick();
    chk("err_pulses", err_seen - e0, 2);
    chk("err_len", message_length_o, 0);

    start(1);
    fifo_wready_i = 0;
    send(32'h00ABCDEF, sb(3));
    send(32'h01020304, sb(4));
    send(32'h05060708, sb(4));
    @(negedge clk_i);
    chk("rs_pending", fifo_wvalid_o, 1);
    tick();
    start(1);
    chk("rs_wvalid", fifo_wvalid_o, 0);
    chk("rs_len", message_length_o, 0);
    chk("rs_ready", msg_ready_o, 1);
    fifo_wready_i = 1;
    flush(2);

    start(1);
    bp_rand = 1;
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom % 100;
      if (r < 4) begin
        flush(0);
        send($urandom, sb(4));
        start(1);
      end else if (r < 6) begin
        start(1);
      end else if (r < 12) begin
        send($urandom, bad[$urandom % 5]);
      end else begin
        send($urandom, sb(1 + ($urandom % 4)));
      end
      repeat ($urandom % 3) tick();
    end
    flush(0);
    bp_rand = 0;
    tick();
    fifo_wready_i = 1;
    repeat (3) tick();
    chk("err_total", err_seen, err_exp);
    chk("exp_empty", m_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
